// File: rtl/alu_pkg.sv
// Shared KLP32 ALU definitions: datapath widths and op encodings for the result mux.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

endpackage

// File: rtl/sll_stage.sv
// One barrel-shifter level: shifts left by STAGE_SHIFT when en is set.
// Latency: combinational.
// Backpressure: none.
module sll_stage
    import alu_pkg::*;
#(
    parameter int STAGE_SHIFT = 1
) (
    input  logic [XLEN-1:0] data,
    input  logic            en,
    output logic [XLEN-1:0] shifted
);

    assign shifted = en ? (data << STAGE_SHIFT) : data;

endmodule

// File: rtl/sll_32.sv
// 32-bit logical left shifter for SLL/SLLI using five log-depth mux stages.
// Latency: 1 cycle, registered result and out_valid.
// Backpressure: none; accepts one operation per cycle.
module sll_32
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] X,
    input  logic [XLEN-1:0] shift,
    input  logic            in_valid,
    output logic [XLEN-1:0] result,
    output logic            out_valid
);

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    stage_dat [SHAMT_W+1];
    logic               unused_shift_hi;

    // RV32I uses only the low five bits of the shift operand.
    assign shamt           = shift[SHAMT_W-1:0];
    assign unused_shift_hi = ^shift[XLEN-1:SHAMT_W];
    assign stage_dat[0]    = X;

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        sll_stage #(
            .STAGE_SHIFT(1 << i)
        ) u_stage (
            .data   (stage_dat[i]),
            .en     (shamt[i]),
            .shifted(stage_dat[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result <= stage_dat[SHAMT_W];
            end
        end
    end

endmodule

// File: tb/tb_sll_32.sv
// Directed and random checks for sll_32: reset, boundary shifts, streaming and idle hold.
module tb_sll_32;

    logic        clk;
    logic        rst_n;
    logic [31:0] X;
    logic [31:0] shift;
    logic        in_valid;
    logic [31:0] result;
    logic        out_valid;

    int n_checks = 0;
    int n_errors = 0;

    sll_32 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .X        (X),
        .shift    (shift),
        .in_valid (in_valid),
        .result   (result),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one valid operation, then check it one edge later.
    task automatic do_op(input string tag, input logic [31:0] x_v, input logic [31:0] s_v,
                         input logic [31:0] exp);
        @(negedge clk);
        X        = x_v;
        shift    = s_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({tag, ".res"}, result, exp);
        check({tag, ".vld"}, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rx, rs;
        rst_n    = 1'b0;
        X        = 32'h0;
        shift    = 32'h0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_res", result, 32'h0);
        check("reset_vld", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("x1_s2",      32'h00000001, 32'd2,         32'h00000004);
        do_op("x0_s31",     32'h00000000, 32'd31,        32'h00000000);
        do_op("xff_s0",     32'hFFFFFFFF, 32'd0,         32'hFFFFFFFF);
        do_op("x80_s31",    32'h80000000, 32'd31,        32'h00000000);
        do_op("a5_s16",     32'hA5A5A5A5, 32'd16,        32'hA5A50000);
        do_op("55_s1",      32'h55555555, 32'd1,         32'hAAAAAAAA);
        do_op("x1_s31",     32'h00000001, 32'd31,        32'h80000000);
        do_op("hi_21",      32'h00000001, 32'h00000021,  32'h00000002);
        do_op("hi_ffe0",    32'h12345678, 32'hFFFFFFE0,  32'h12345678);
        do_op("s32",        32'hDEADBEEF, 32'd32,        32'hDEADBEEF);
        do_op("s4",         32'h0000F00F, 32'd4,         32'h000F00F0);

        // Four back-to-back ops followed by an idle cycle.
        do_op("pipe0",      32'h00000003, 32'd1,         32'h00000006);
        do_op("pipe1",      32'h0000000F, 32'd8,         32'h00000F00);
        do_op("pipe2",      32'h12345678, 32'd12,        32'h45678000);
        do_op("pipe3",      32'hCAFEBABE, 32'd3,         32'h57F5D5F0);
        @(negedge clk);
        in_valid = 1'b0;
        X        = 32'hFFFFFFFF;
        shift    = 32'd5;
        @(posedge clk);
        #1;
        check("gap_vld", {31'b0, out_valid}, 32'd0);
        check("gap_hold", result, 32'h57F5D5F0);
        @(posedge clk);
        #1;
        check("gap2_hold", result, 32'h57F5D5F0);

        // Asynchronous reset mid-cycle with a transfer pending.
        @(negedge clk);
        X        = 32'h00000001;
        shift    = 32'd4;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_res", result, 32'h0);
        check("async_vld", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("held_res", result, 32'h0);
        check("held_vld", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_vld", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_res", result, 32'h00000010);
        check("post_rst_vld", {31'b0, out_valid}, 32'd1);

        for (int i = 0; i < 1000; i++) begin
            rx = $urandom;
            rs = $urandom;
            do_op("rand", rx, rs, rx << rs[4:0]);
        end

        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("end_vld", {31'b0, out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
